timer_counter: RTL and testbench



---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_counter.sv | 109 ++++++++++
 tb/tb_timer_counter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
// Holds the FSM state encoding, register offsets (word-address bits [3:2]),
// CTRL field positions, MODE constants and the two instance base addresses
// so the bus bridge can reuse the same constants for its range decode.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

    // Reserved MODE encodings 10/11 fall back to one-shot behaviour.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit memory-mapped down-counting timer with interrupt.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for CTRL.EN; entering LOAD clears irq_flag
// LOAD    | COUNT <= PRESET
// CNT     | decrement COUNT; at <=1 go to zero and raise irq_flag
// INT     | one-shot clears EN, auto-reload drops irq_flag
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   Addr  - word address [31:2]; only bits [3:2] (Addr[1:0] here) decoded
//   WE    - write enable from the bridge
//   Din   - write data
//   Dout  - combinational read data for the selected register
//   IRQ   - interrupt request (irq_flag gated by CTRL.IM)
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;

    logic [1:0]  sel;
    logic        addr_unused;

    // Addr[1:0] of the word address corresponds to byte-address bits [3:2].
    assign sel         = Addr[1:0];
    assign addr_unused = ^Addr[29:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            state    <= ST_IDLE;
        end else if (WE) begin
            // A bus write freezes the FSM and COUNT for this cycle.
            case (sel)
                OFF_CTRL: begin
                    ctrl     <= Din[3:0];
                    irq_flag <= 1'b0;
                end
                OFF_PRESET: preset <= Din;
                default: ;
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN]) begin
                        state    <= ST_LOAD;
                        irq_flag <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Covers both COUNT==1 and a PRESET of 0, so no wrap.
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            OFF_CTRL:   Dout = {28'd0, ctrl};
            OFF_PRESET: Dout = preset;
            OFF_COUNT:  Dout = count;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter. Expected values come from the
// latency rules of the timer (load two edges after enable, one decrement
// per edge, interrupt max(PRESET,1)+2 edges after enable, reload period
// max(PRESET,1)+3) evaluated with plain arithmetic.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] Addr = 30'd0;
    logic        WE = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] A_CTRL = 2'b00;
    localparam logic [1:0] A_PRE  = 2'b01;
    localparam logic [1:0] A_CNT  = 2'b10;
    localparam logic [1:0] A_UNM  = 2'b11;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        Addr = {28'd0, off};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] v);
        Addr = {28'd0, off};
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        WE    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_read off=%0d got=%h exp=0", i, v);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        tick();
        for (int k = 2; k <= 7; k++) begin
            tick();
            rd(A_CNT, v);
            checks++;
            if (v !== 32'(7 - k)) begin
                errors++;
                $display("FAIL oneshot_count E%0d got=%0d exp=%0d", k, v, 7 - k);
            end
            checks++;
            if (IRQ !== (k == 7)) begin
                errors++;
                $display("FAIL oneshot_irq E%0d got=%b exp=%b", k, IRQ, k == 7);
            end
        end
        tick();
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl_en_clear got=%h exp=8", v);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_hold got=%b exp=1", IRQ);
        end
        wr(A_CTRL, 32'h0);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_reload();
        logic [31:0] v;
        int ph;
        int exp_c;
        do_reset();
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 19; k++) begin
            tick();
            rd(A_CNT, v);
            ph = (k - 2) % 6;
            exp_c = (k < 2) ? 0 : ((ph < 3) ? 3 - ph : 0);
            checks++;
            if (v !== 32'(exp_c)) begin
                errors++;
                $display("FAIL reload_count E%0d got=%0d exp=%0d", k, v, exp_c);
            end
            checks++;
            if (IRQ !== (k >= 5 && (k - 5) % 6 == 0)) begin
                errors++;
                $display("FAIL reload_irq E%0d got=%b exp=%b", k, IRQ,
                         k >= 5 && (k - 5) % 6 == 0);
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        do_reset();
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL mask_irq E%0d got=%b exp=0", k, IRQ);
            end
        end
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL mask_ctrl got=%h exp=0", v);
        end
        wr(A_CTRL, 32'h8);
        tick();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL mask_unmask_after_clear got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_disable();
        logic [31:0] v;
        do_reset();
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 6; k++) tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL disable_pre got=%0d exp=6", v);
        end
        wr(A_CTRL, 32'h8);
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL disable_irq cyc=%0d got=%b exp=0", k, IRQ);
            end
        end
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL disable_hold got=%0d exp=6", v);
        end
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("FAIL disable_reload got=%0d exp=10", v);
        end
    endtask

    task automatic test_edges();
        logic [31:0] v;
        do_reset();
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (IRQ !== (k == 3)) begin
                errors++;
                $display("FAIL preset0_irq E%0d got=%b exp=%b", k, IRQ, k == 3);
            end
        end
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'hF) begin
            errors++;
            $display("FAIL ctrl_wide got=%h exp=f", v);
        end
        do_reset();
        wr(A_CNT, 32'h1234_5678);
        wr(A_UNM, 32'hDEAD_BEEF);
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL count_write_ignored got=%h exp=0", v);
        end
        rd(A_UNM, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read got=%h exp=0", v);
        end
        // stall: three back-to-back PRESET writes freeze the countdown
        wr(A_PRE, 32'd8);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 3; k++) tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL stall_pre got=%0d exp=7", v);
        end
        for (int k = 0; k < 3; k++) wr(A_PRE, 32'd100);
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL stall_hold got=%0d exp=7", v);
        end
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL stall_resume got=%0d exp=6", v);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL stall_irq_early got=%b exp=0", IRQ);
        end
        tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL stall_irq got=%b exp=1", IRQ);
        end
        tick();
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd100) begin
            errors++;
            $display("FAIL preset_next_load got=%0d exp=100", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        do_reset();
        wr(A_PRE, 32'd20);
        wr(A_CTRL, 32'hF);
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(i[1:0], v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid off=%0d got=%h exp=0", i, v);
            end
        end
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== 32'd0 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle count=%0d irq=%b exp=0/0", v, IRQ);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        int p, pe, mode, im, per, ph, exp_c, n;
        logic exp_flag;
        logic [31:0] exp_ctrl;
        for (int it = 0; it < 16; it++) begin
            do_reset();
            p    = int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 3));
            im   = int'($urandom_range(0, 1));
            pe   = (p < 1) ? 1 : p;
            per  = pe + 3;
            n    = 2 * per + 4;
            wr(A_PRE, 32'(p));
            wr(A_CTRL, 32'((im << 3) | (mode << 1) | 1));
            for (int k = 1; k <= n; k++) begin
                tick();
                if (k < 2) begin
                    exp_c = 0;
                    exp_flag = 1'b0;
                end else if (mode == 1) begin
                    ph = (k - 2) % per;
                    exp_c = (ph < pe) ? p - ph : 0;
                    exp_flag = (ph == pe);
                end else begin
                    exp_c = (k - 2 < pe) ? p - (k - 2) : 0;
                    exp_flag = (k >= pe + 2);
                end
                rd(A_CNT, v);
                checks++;
                if (v !== 32'(exp_c) || IRQ !== (exp_flag & (im == 1))) begin
                    errors++;
                    $display("FAIL rand it=%0d p=%0d mode=%0d im=%0d E%0d count=%0d irq=%b exp=%0d/%b",
                             it, p, mode, im, k, v, IRQ, exp_c, exp_flag & (im == 1));
                end
            end
            exp_ctrl = 32'((im << 3) | (mode << 1) | ((mode == 1) ? 1 : 0));
            rd(A_CTRL, v);
            checks++;
            if (v !== exp_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl it=%0d got=%h exp=%h", it, v, exp_ctrl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_disable();
        test_edges();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
